// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings and counter-width helper for the wall-clock sequencing controller.
package clock_ctrl_pkg;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/clock_ctrl_btn_sync.sv
// Two-flop synchronizer for an asynchronous button, plus a previous-value flop for rise detection.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchronizer chain and previous-level flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= btn;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign level = s2_r;
    assign rise  = s2_r & ~s3_r;

endmodule

// File: rtl/clock_ctrl.sv
// Wall-clock sequencer: 1 Hz prescaler, carry chaining in RUN, and button-driven hour/minute setting.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DIV       = 50000000,
    parameter int BLINK_DIV = 25000000,
    parameter int HOLD      = 25000000,
    parameter int REP       = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       co_sec,
    input  logic       co_min,
    output logic       ci_sec,
    output logic       ci_min,
    output logic       ci_hour,
    output logic       clr_sec,
    output logic [1:0] mode,
    output logic       blink,
    output logic       tick
);

    localparam int PW = cnt_width(DIV);
    localparam int BW = cnt_width(BLINK_DIV);
    localparam int HW = cnt_width(HOLD);

    localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD - REP);

    logic          mode_lvl_s;
    logic          mode_rise_s;
    logic          inc_lvl_s;
    logic          inc_rise_s;
    logic          mode_evt_s;
    logic          set_mode_s;
    logic          rep_s;
    logic          inc_evt_s;
    logic          tick_s;
    logic [1:0]    mode_nxt_s;

    logic [1:0]    mode_r;
    logic          clr_sec_r;
    logic [PW-1:0] presc_r;
    logic [BW-1:0] blink_cnt_r;
    logic          blink_r;
    logic [HW-1:0] hold_r;

    btn_sync u_mode_sync (
        .clk   (clk),
        .rst   (rst),
        .btn   (mode_btn),
        .level (mode_lvl_s),
        .rise  (mode_rise_s)
    );

    btn_sync u_inc_sync (
        .clk   (clk),
        .rst   (rst),
        .btn   (inc_btn),
        .level (inc_lvl_s),
        .rise  (inc_rise_s)
    );

    assign mode_evt_s = mode_rise_s & mode_lvl_s;
    assign set_mode_s = (mode_r == MODE_SET_HOUR) || (mode_r == MODE_SET_MIN);
    assign tick_s     = (mode_r == MODE_RUN) && (presc_r == PRESC_LAST);
    assign rep_s      = set_mode_s & inc_lvl_s & (hold_r == HOLD_LAST);
    // A mode press in the same cycle swallows the increment.
    assign inc_evt_s  = set_mode_s & ~mode_evt_s & (inc_rise_s | rep_s);

    // Next-mode selection; the unused encoding falls back to RUN.
    always_comb begin
        mode_nxt_s = MODE_RUN;
        case (mode_r)
            MODE_RUN: begin
                if (mode_evt_s) mode_nxt_s = MODE_SET_HOUR;
                else            mode_nxt_s = MODE_RUN;
            end
            MODE_SET_HOUR: begin
                if (mode_evt_s) mode_nxt_s = MODE_SET_MIN;
                else            mode_nxt_s = MODE_SET_HOUR;
            end
            MODE_SET_MIN: begin
                if (mode_evt_s) mode_nxt_s = MODE_RUN;
                else            mode_nxt_s = MODE_SET_MIN;
            end
            default: mode_nxt_s = MODE_RUN;
        endcase
    end

    // Mode register and the one-shot seconds clear on entering SET_HOUR.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r    <= MODE_RUN;
            clr_sec_r <= 1'b0;
        end else begin
            mode_r    <= mode_nxt_s;
            clr_sec_r <= (mode_r == MODE_RUN) & mode_evt_s;
        end
    end

    // 1 Hz prescaler, parked at zero outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else if (mode_r != MODE_RUN) begin
            presc_r <= '0;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1'b1);
        end
    end

    // Auto-repeat hold counter; reloads so later repeats come every REP cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r <= '0;
        end else if (!set_mode_s || !inc_lvl_s || mode_evt_s || inc_rise_s) begin
            hold_r <= '0;
        end else if (hold_r == HOLD_LAST) begin
            hold_r <= HOLD_RELOAD;
        end else begin
            hold_r <= hold_r + HW'(1'b1);
        end
    end

    // Blink phase: restarts high on each set-mode entry, forced low in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if (mode_evt_s) begin
            blink_cnt_r <= '0;
            blink_r     <= (mode_nxt_s != MODE_RUN);
        end else if (!set_mode_s) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            blink_r     <= ~blink_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BW'(1'b1);
            blink_r     <= blink_r;
        end
    end

    // Counter enables; minutes never carry into hours while setting.
    always_comb begin
        ci_sec  = 1'b0;
        ci_min  = 1'b0;
        ci_hour = 1'b0;
        case (mode_r)
            MODE_RUN: begin
                ci_sec  = tick_s;
                ci_min  = co_sec;
                ci_hour = co_min;
            end
            MODE_SET_HOUR: ci_hour = inc_evt_s;
            MODE_SET_MIN:  ci_min  = inc_evt_s;
            default: begin
                ci_sec  = 1'b0;
                ci_min  = 1'b0;
                ci_hour = 1'b0;
            end
        endcase
    end

    assign mode    = mode_r;
    assign clr_sec = clr_sec_r;
    assign blink   = blink_r;
    assign tick    = tick_s;

endmodule
